hazard_scoreboard_ctrl: RTL and testbench
=========================================

// Module: hazard_scoreboard_ctrl
// PURPOSE
//  Issue scheduler between decode (ID) and execute (EX) of the 32-bit MIPS-subset core.
//  Tracks in-flight register writes in a per-register countdown scoreboard.
//  Stalls ID on RAW/WAW hazards, squashes wrong-path instructions after taken beq/j,
//  and drives the registered ex_nop bubble into the control path.
// PARAMETERS
//  NREGS        32  architectural registers; r0 is never busy
//  REG_AW        5  register index width, clog2(NREGS)
//  WB_LAT        3  cycles from issue until the result is readable in the register file (1..7)
//  FLUSH_SLOTS   1  ID-valid slots killed per taken branch/jump, counting the branch cycle (1..3)
//  CNT_W        16  width of stall performance counter
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       reset, asynchronous, active-high
//  id_valid       in   1       ID holds a real instruction
//  id_rs          in   REG_AW  source register 1
//  id_rt          in   REG_AW  source register 2
//  id_uses_rs     in   1       instruction reads rs
//  id_uses_rt     in   1       instruction reads rt (R-type, sw, beq)
//  id_writes_reg  in   1       instruction writes id_rd (R-type, addi, lw)
//  id_rd          in   REG_AW  destination register
//  ex_redirect    in   1       taken beq or j resolved in EX this cycle
//  stall          out  1       comb.: hold PC and IF/ID register
//  issue          out  1       comb.: ID instruction advances to EX this cycle
//  kill_id        out  1       comb.: ID instruction is wrong-path, discarded
//  ex_nop         out  1       reg.: EX slot holds a bubble (drives control path is_nop)
//  busy_mask      out  NREGS   reg.: bit i set while cnt[i] != 0
//  stall_cycles   out  CNT_W   reg.: saturating count of cycles with stall=1
// BEHAVIOUR
//  - Reset: all cnt[i]=0, squash_cnt=0, ex_nop=1, busy_mask=0, stall_cycles=0.
//    Reset mid-operation discards all pending hazards and squashes at once.
//  - Scoreboard: cnt[i] is 3 bits. Every cycle a nonzero cnt decrements by 1.
//    On issue with id_writes_reg and id_rd!=0: cnt[id_rd] <= WB_LAT; the load overrides the decrement.
//  - Hazard: haz = (id_uses_rs & cnt[id_rs]!=0) | (id_uses_rt & cnt[id_rt]!=0)
//                | (id_writes_reg & cnt[id_rd]!=0). Index 0 never causes a hazard.
//  - kill_id = id_valid & (ex_redirect | squash_cnt!=0).
//  - stall = id_valid & haz & ~kill_id. Kill takes priority over stall.
//  - issue = id_valid & ~haz & ~kill_id.
//  - ex_nop <= ~issue. Stalled, killed and invalid slots all produce a bubble next cycle.
//  - Squash: on ex_redirect, squash_cnt <= FLUSH_SLOTS-1, overriding the decrement.
//    Otherwise squash_cnt decrements on cycles with id_valid & squash_cnt!=0.
//    Killed instructions never update the scoreboard.
//  - A back-to-back dependent instruction stalls exactly WB_LAT cycles, then issues.
//    Dependence at distance d stalls max(0, WB_LAT-d+1) cycles.
//  - stall_cycles increments on stall and holds at 2^CNT_W-1.
//  - busy_mask is derived from the registered cnt values. No comb. path from inputs to busy_mask or ex_nop.
// TESTING
//  1. rst pulse mid-stall -> stall=0, ex_nop=1, busy_mask=0 immediately; first valid instr next cycle issues.
//  2. addi r5 issued at cycle 0; add r6,r5,r1 in ID at cycle 1 -> stall=1 cycles 1-3, issue=1 cycle 4, stall_cycles=3.
//  3. Writes to r0 back-to-back, then read r0 -> no stall; busy_mask[0] stays 0.
//  4. lw r7 issued, then addi r7 (WAW, no rs use) next cycle -> 3-cycle stall; then cnt[7] reloads to 3.
//  5. ex_redirect while ID instr is stalled on r5 -> kill_id=1, stall=0, issue=0; next cycle ex_nop=1, cnt unchanged.
//  6. FLUSH_SLOTS=2: ex_redirect at cycle 10 with id_valid=0 at cycles 11-12, valid at 13
//     -> kill_id at cycles 10 and 13, issue at cycle 14.
//     Saturation: force stall for 2^CNT_W+5 cycles -> stall_cycles=0xFFFF.

Source files
------------

// File: rtl/hazard_scoreboard_ctrl.sv
// ID->EX issue scheduler: per-register countdown scoreboard for RAW/WAW stalls,
// wrong-path squash after taken branches/jumps, and the registered EX bubble.
module hazard_scoreboard_ctrl #(
  parameter int NREGS       = 32,
  parameter int REG_AW      = 5,
  parameter int WB_LAT      = 3,
  parameter int FLUSH_SLOTS = 1,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_writes_reg,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_redirect,
  output logic              stall,
  output logic              issue,
  output logic              kill_id,
  output logic              ex_nop,
  output logic [NREGS-1:0]  busy_mask,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam logic [2:0] WB_LOAD    = 3'(WB_LAT);
  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_SLOTS - 1);

  logic [2:0] cnt [NREGS];
  logic [1:0] squash_cnt;
  logic       rs_busy, rt_busy, rd_busy, haz;

  // Handshake: ID offers an instruction with id_valid; it is consumed (moves to
  // EX) only in a cycle with issue=1, discarded with kill_id=1, and must be held
  // unchanged while stall=1. Exactly one of the three is set when id_valid=1.
  always_comb begin
    rs_busy = id_uses_rs    && (id_rs != '0) && (cnt[id_rs] != 3'd0);
    rt_busy = id_uses_rt    && (id_rt != '0) && (cnt[id_rt] != 3'd0);
    rd_busy = id_writes_reg && (id_rd != '0) && (cnt[id_rd] != 3'd0);
    haz     = rs_busy || rt_busy || rd_busy;
  end

  assign kill_id = id_valid && (ex_redirect || (squash_cnt != 2'd0));
  assign stall   = id_valid && haz && !kill_id;
  assign issue   = id_valid && !haz && !kill_id;

  // A fresh write reservation overrides the countdown; r0 is never reserved.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) cnt[i] <= 3'd0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (issue && id_writes_reg && (i != 0) && (id_rd == i[REG_AW-1:0]))
          cnt[i] <= WB_LOAD;
        else if (cnt[i] != 3'd0)
          cnt[i] <= cnt[i] - 3'd1;
      end
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < NREGS; i++) busy_mask[i] = (cnt[i] != 3'd0);
  end

  // Remaining wrong-path slots only count down when a valid instruction is killed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      squash_cnt <= 2'd0;
    else if (ex_redirect)
      squash_cnt <= FLUSH_LOAD;
    else if (id_valid && (squash_cnt != 2'd0))
      squash_cnt <= squash_cnt - 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ex_nop <= 1'b1;
    else     ex_nop <= !issue;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cycles <= '0;
    else if (stall && (stall_cycles != '1))
      stall_cycles <= stall_cycles + 1'b1;
  end

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Directed bench for hazard_scoreboard_ctrl: a default instance driven from a
// vector table, plus a WB_LAT=7/FLUSH_SLOTS=2/CNT_W=10 instance for squash and saturation.
module tb_hazard_scoreboard_ctrl;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       wr;
    logic [4:0] rd;
    logic       redir;
  } in_t;

  typedef struct packed {
    in_t         in;
    logic        e_stall;
    logic        e_issue;
    logic        e_kill;
    logic        e_nop;
    logic [31:0] e_busy;
    logic [15:0] e_sc;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  in_t  a, b;

  logic        stall_a, issue_a, kill_a, nop_a;
  logic [31:0] busy_a;
  logic [15:0] sc_a;
  logic        stall_b, issue_b, kill_b, nop_b;
  logic [31:0] busy_b;
  logic [9:0]  sc_b;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  vec_t vecs[19];

  always #5 clk = ~clk;

  hazard_scoreboard_ctrl dut_a (
    .clk(clk), .rst(rst),
    .id_valid(a.valid), .id_rs(a.rs), .id_rt(a.rt),
    .id_uses_rs(a.urs), .id_uses_rt(a.urt),
    .id_writes_reg(a.wr), .id_rd(a.rd), .ex_redirect(a.redir),
    .stall(stall_a), .issue(issue_a), .kill_id(kill_a), .ex_nop(nop_a),
    .busy_mask(busy_a), .stall_cycles(sc_a)
  );

  hazard_scoreboard_ctrl #(.WB_LAT(7), .FLUSH_SLOTS(2), .CNT_W(10)) dut_b (
    .clk(clk), .rst(rst),
    .id_valid(b.valid), .id_rs(b.rs), .id_rt(b.rt),
    .id_uses_rs(b.urs), .id_uses_rt(b.urt),
    .id_writes_reg(b.wr), .id_rd(b.rd), .ex_redirect(b.redir),
    .stall(stall_b), .issue(issue_b), .kill_id(kill_b), .ex_nop(nop_b),
    .busy_mask(busy_b), .stall_cycles(sc_b)
  );

  function automatic in_t mk_in(logic v, logic [4:0] rs, logic [4:0] rt, logic urs,
                                logic urt, logic wr, logic [4:0] rd, logic redir);
    in_t r;
    r.valid = v; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt;
    r.wr = wr; r.rd = rd; r.redir = redir;
    return r;
  endfunction

  function automatic vec_t mk(in_t in, logic s, logic i, logic k, logic n,
                              logic [31:0] busy, logic [15:0] sc);
    vec_t r;
    r.in = in; r.e_stall = s; r.e_issue = i; r.e_kill = k; r.e_nop = n;
    r.e_busy = busy; r.e_sc = sc;
    return r;
  endfunction

  function automatic logic [31:0] bit_of(int n);
    logic [31:0] one = 32'd1;
    return one << n;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_a(in_t in);
    @(negedge clk);
    a = in;
    #1;
  endtask

  task automatic apply_b(in_t in);
    @(negedge clk);
    b = in;
    #1;
  endtask

  in_t idle, add_r6_r5, dep_r1;

  initial begin
    idle      = mk_in(0, 0, 0, 0, 0, 0, 0, 0);
    add_r6_r5 = mk_in(1, 5, 1, 1, 1, 1, 6, 0);
    a = idle;
    b = idle;

    // v0-4: addi r5 then dependent add r6,r5,r1 -> 3 stall cycles
    vecs[0]  = mk(mk_in(1, 1, 0, 1, 0, 1, 5, 0), 0, 1, 0, 1, 0, 0);
    vecs[1]  = mk(add_r6_r5, 1, 0, 0, 0, bit_of(5), 0);
    vecs[2]  = mk(add_r6_r5, 1, 0, 0, 1, bit_of(5), 1);
    vecs[3]  = mk(add_r6_r5, 1, 0, 0, 1, bit_of(5), 2);
    vecs[4]  = mk(add_r6_r5, 0, 1, 0, 1, 0, 3);
    // v5-7: writes to r0 back-to-back, then read r0: no hazard
    vecs[5]  = mk(mk_in(1, 1, 0, 1, 0, 1, 0, 0), 0, 1, 0, 0, bit_of(6), 3);
    vecs[6]  = mk(mk_in(1, 1, 0, 1, 0, 1, 0, 0), 0, 1, 0, 0, bit_of(6), 3);
    vecs[7]  = mk(mk_in(1, 0, 0, 1, 1, 1, 2, 0), 0, 1, 0, 0, bit_of(6), 3);
    // v8-13: lw r7 then WAW addi r7, then cnt[7] reloads
    vecs[8]  = mk(mk_in(1, 3, 0, 1, 0, 1, 7, 0), 0, 1, 0, 0, bit_of(2), 3);
    vecs[9]  = mk(mk_in(1, 7, 0, 0, 0, 1, 7, 0), 1, 0, 0, 0, bit_of(2) | bit_of(7), 3);
    vecs[10] = mk(mk_in(1, 7, 0, 0, 0, 1, 7, 0), 1, 0, 0, 1, bit_of(2) | bit_of(7), 4);
    vecs[11] = mk(mk_in(1, 7, 0, 0, 0, 1, 7, 0), 1, 0, 0, 1, bit_of(7), 5);
    vecs[12] = mk(mk_in(1, 7, 0, 0, 0, 1, 7, 0), 0, 1, 0, 1, 0, 6);
    vecs[13] = mk(idle, 0, 0, 0, 0, bit_of(7), 6);
    // v14-18: redirect while stalled on r5 kills, scoreboard only counts down
    vecs[14] = mk(mk_in(1, 1, 0, 1, 0, 1, 5, 0), 0, 1, 0, 1, bit_of(7), 6);
    vecs[15] = mk(mk_in(1, 5, 0, 1, 0, 1, 6, 0), 1, 0, 0, 0, bit_of(5) | bit_of(7), 6);
    vecs[16] = mk(mk_in(1, 5, 0, 1, 0, 1, 6, 1), 0, 0, 1, 1, bit_of(5), 7);
    vecs[17] = mk(idle, 0, 0, 0, 1, bit_of(5), 7);
    vecs[18] = mk(mk_in(1, 5, 0, 1, 0, 1, 9, 0), 0, 1, 0, 1, 0, 7);

    // Reset state
    #12;
    check("reset_ex_nop", 32'(nop_a), 1);
    check("reset_busy", busy_a, 0);
    check("reset_sc", 32'(sc_a), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      exp_q.push_back(vecs[i].e_busy);
      apply_a(vecs[i].in);
      check($sformatf("v%0d_stall", i), 32'(stall_a), 32'(vecs[i].e_stall));
      check($sformatf("v%0d_issue", i), 32'(issue_a), 32'(vecs[i].e_issue));
      check($sformatf("v%0d_kill", i), 32'(kill_a), 32'(vecs[i].e_kill));
      check($sformatf("v%0d_ex_nop", i), 32'(nop_a), 32'(vecs[i].e_nop));
      check($sformatf("v%0d_busy", i), busy_a, exp_q.pop_front());
      check($sformatf("v%0d_sc", i), 32'(sc_a), 32'(vecs[i].e_sc));
    end

    // Asynchronous reset in the middle of a stall on r9
    apply_a(mk_in(1, 9, 0, 1, 0, 1, 4, 0));
    check("prerst_stall", 32'(stall_a), 1);
    #2 rst = 1'b1;
    #1;
    check("rst_stall", 32'(stall_a), 0);
    check("rst_ex_nop", 32'(nop_a), 1);
    check("rst_busy", busy_a, 0);
    check("rst_sc", 32'(sc_a), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("postrst_issue", 32'(issue_a), 1);
    apply_a(idle);
    check("postrst_busy", busy_a, bit_of(4));

    // FLUSH_SLOTS=2: redirect, two empty slots, then one more kill
    apply_b(mk_in(1, 1, 0, 1, 0, 1, 3, 1));
    check("sq_redirect_kill", 32'(kill_b), 1);
    check("sq_redirect_issue", 32'(issue_b), 0);
    apply_b(idle);
    check("sq_idle1_kill", 32'(kill_b), 0);
    check("sq_idle1_nop", 32'(nop_b), 1);
    apply_b(idle);
    check("sq_idle2_kill", 32'(kill_b), 0);
    apply_b(mk_in(1, 1, 0, 1, 0, 1, 3, 0));
    check("sq_valid_kill", 32'(kill_b), 1);
    check("sq_valid_issue", 32'(issue_b), 0);
    apply_b(mk_in(1, 1, 0, 1, 0, 1, 3, 0));
    check("sq_after_kill", 32'(kill_b), 0);
    check("sq_after_issue", 32'(issue_b), 1);
    check("sq_after_busy", busy_b, 0);

    // Self-dependent r1 chain at WB_LAT=7: issue, 7 stalls, repeat; saturates stall_cycles
    dep_r1 = mk_in(1, 1, 0, 1, 0, 1, 1, 0);
    for (int k = 0; k < 1200; k++) begin
      apply_b(dep_r1);
      if (k < 40 || k % 97 == 0)
        check($sformatf("chain%0d_issue", k), 32'(issue_b), 32'((k % 8) == 0));
      if (k == 16)
        check("chain_sc_count", 32'(sc_b), 14);
    end
    check("sat_sc", 32'(sc_b), 32'h3FF);
    apply_b(idle);
    check("sat_sc_hold", 32'(sc_b), 32'h3FF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
